itcm_fch_slv: RTL and testbench

Instruction-memory fetch responder. It terminates the core's fetch channel: it accepts `fch_req` packets carrying a PC, reads one 32-bit word from a synchronous single-port instruction SRAM, and returns it in order on `fch_rsp`. A small response FIFO absorbs back-pressure from the fetch unit, so no SRAM read is ever lost or repeated.

---
 rtl/itcm_pkg.sv | 27 ++
 rtl/itcm_fch_if.sv | 18 +
 rtl/itcm_fch_slv_fifo.sv | 66 ++++++
 rtl/itcm_fch_slv.sv | 104 ++++++++++
 tb/tb_itcm_fch_slv.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/itcm_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
`ifndef RV_PC_SIZE
`define RV_PC_SIZE 32
`endif
`ifndef RV_IR_SIZE
`define RV_IR_SIZE 32
`endif

package itcm_pkg;

  typedef logic [31:0] rsp_word_t;

  localparam rsp_word_t FCH_FAULT_IR = 32'h0000_0000;

  typedef struct packed {
    logic [`RV_PC_SIZE-1:0] pc;
  } fch_req_pkt_t;

  typedef struct packed {
    logic [`RV_IR_SIZE-1:0] ir;
  } fch_rsp_pkt_t;

  function automatic int itcm_aw(int words);
    return $clog2(words);
  endfunction

endpackage

// File: rtl/itcm_fch_if.sv
// Fetch request and response channels as valid/ready interfaces.
interface fch_req_if;
  import itcm_pkg::*;
  logic         vld;
  logic         rdy;
  fch_req_pkt_t pkt;
  modport slv (input vld, input pkt, output rdy);
  modport mst (output vld, output pkt, input rdy);
endinterface

interface fch_rsp_if;
  import itcm_pkg::*;
  logic         vld;
  logic         rdy;
  fch_rsp_pkt_t pkt;
  modport slv (input vld, input pkt, output rdy);
  modport mst (output vld, output pkt, input rdy);
endinterface

// File: rtl/itcm_fch_slv_fifo.sv
// Small synchronous response FIFO; pointers wrap by compare-and-reset so any depth works.
module fch_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    empty    = (cnt_q == '0);
    full     = (cnt_q == CW'(DEPTH));
    rdata    = mem_q[rd_ptr_q];
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/itcm_fch_slv.sv
// Fetch responder: accepts PCs, reads the instruction SRAM and returns words in order,
// bypassing the response FIFO whenever the fetch unit is ready and nothing is queued.
module itcm_fch_slv
  import itcm_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int RSP_DEPTH = 2,
  localparam int AW = itcm_aw(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  fch_req_if.slv        fch_req_slv,
  fch_rsp_if.mst        fch_rsp_mst,
  output logic          sram_ce,
  output logic [AW-1:0] sram_addr,
  input  logic [31:0]   sram_rdata,
  output logic          fault
);

  localparam int OW = $clog2(RSP_DEPTH + 1);

  logic [OW-1:0]          occ_q, occ_d;
  logic                   rd_vld_q, rd_vld_d;
  logic                   rd_bad_q, rd_bad_d;
  logic                   fault_q, fault_d;
  logic [`RV_PC_SIZE-1:0] pc;
  logic                   pc_bad;
  logic                   req_rdy, req_hsk;
  logic                   rsp_vld, rsp_hsk;
  logic                   bypass;
  rsp_word_t              rd_word, rsp_ir;
  rsp_word_t              fifo_rdata;
  logic                   fifo_push, fifo_pop, fifo_empty, fifo_full;

  fch_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH ($bits(rsp_word_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (rd_word),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Ready also opens in the same cycle a response leaves, keeping full throughput at the occ bound.
  always_comb begin
    pc        = fch_req_slv.pkt.pc;
    pc_bad    = (pc[1:0] != 2'b00) || ((pc >> (AW + 2)) != '0);
    rsp_vld   = rst_n & (~fifo_empty | rd_vld_q);
    rsp_hsk   = rsp_vld & fch_rsp_mst.rdy;
    req_rdy   = rst_n & ((occ_q < OW'(RSP_DEPTH)) | rsp_hsk);
    req_hsk   = fch_req_slv.vld & req_rdy;
    sram_ce   = req_hsk & ~pc_bad;
    sram_addr = pc[AW+1:2];
    rd_word   = rd_bad_q ? FCH_FAULT_IR : sram_rdata;
    bypass    = fifo_empty & fch_rsp_mst.rdy;
    fifo_push = rst_n & rd_vld_q & ~bypass;
    fifo_pop  = rst_n & ~fifo_empty & fch_rsp_mst.rdy;
    rsp_ir    = '0;
    if (rst_n) begin
      if (!fifo_empty) begin
        rsp_ir = fifo_rdata;
      end else if (rd_vld_q) begin
        rsp_ir = rd_word;
      end
    end
    occ_d = occ_q;
    if (req_hsk && !rsp_hsk) begin
      occ_d = occ_q + 1'b1;
    end else if (rsp_hsk && !req_hsk) begin
      occ_d = occ_q - 1'b1;
    end
    rd_vld_d = req_hsk;
    rd_bad_d = req_hsk & pc_bad;
    fault_d  = fault_q | (req_hsk & pc_bad);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_bad_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      occ_q    <= occ_d;
      rd_vld_q <= rd_vld_d;
      rd_bad_q <= rd_bad_d;
      fault_q  <= fault_d;
    end
  end

  assign fch_req_slv.rdy    = req_rdy;
  assign fch_rsp_mst.vld    = rsp_vld;
  assign fch_rsp_mst.pkt.ir = rsp_ir;
  assign fault              = fault_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_itcm_fch_slv.sv
// Randomized self-checking bench for itcm_fch_slv with a queue-based reference model.
module tb_itcm_fch_slv;
  import itcm_pkg::*;

  localparam int MEM_WORDS = 4096;
  localparam int RSP_DEPTH = 2;
  localparam int AW        = $clog2(MEM_WORDS);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sram_ce;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_rdata;
  logic          fault;

  fch_req_if req_if ();
  fch_rsp_if rsp_if ();

  itcm_fch_slv #(
    .MEM_WORDS (MEM_WORDS),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fch_req_slv (req_if),
    .fch_rsp_mst (rsp_if),
    .sram_ce     (sram_ce),
    .sram_addr   (sram_addr),
    .sram_rdata  (sram_rdata),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: one-cycle read latency, garbage when not enabled
  logic [31:0] mem [MEM_WORDS];

  always @(posedge clk) begin
    if (sram_ce) sram_rdata <= mem[sram_addr];
    else         sram_rdata <= $urandom;
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: queue of expected words for accepted-but-unanswered requests
  logic [31:0] exp_q [$];
  logic        m_fault = 1'b0;

  always @(negedge clk) begin
    logic [31:0] pc;
    logic        bad, exp_rdy, exp_ce;
    pc = req_if.pkt.pc;
    if (!rst_n) begin
      checkOutput("rst_req_rdy", {31'b0, req_if.rdy}, 32'd0);
      checkOutput("rst_rsp_vld", {31'b0, rsp_if.vld}, 32'd0);
      checkOutput("rst_sram_ce", {31'b0, sram_ce}, 32'd0);
      checkOutput("rst_ir", rsp_if.pkt.ir, 32'd0);
      exp_q.delete();
      m_fault = 1'b0;
    end else begin
      bad     = (pc[1:0] != 2'b00) || (pc >= MEM_WORDS * 4);
      exp_rdy = (exp_q.size() < RSP_DEPTH) || (exp_q.size() != 0 && rsp_if.rdy);
      exp_ce  = req_if.vld && exp_rdy && !bad;
      checkOutput("req_rdy", {31'b0, req_if.rdy}, {31'b0, exp_rdy});
      checkOutput("rsp_vld", {31'b0, rsp_if.vld}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() != 0) checkOutput("rsp_ir", rsp_if.pkt.ir, exp_q[0]);
      checkOutput("sram_ce", {31'b0, sram_ce}, {31'b0, exp_ce});
      if (exp_ce) checkOutput("sram_addr", {20'b0, sram_addr}, pc >> 2);
      checkOutput("fault", {31'b0, fault}, {31'b0, m_fault});
      if (exp_q.size() != 0 && rsp_if.rdy) void'(exp_q.pop_front());
      if (req_if.vld && exp_rdy) begin
        exp_q.push_back(bad ? 32'h0 : mem[pc >> 2]);
        if (bad) m_fault = 1'b1;
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic vld, input logic [31:0] pc,
                               input logic rrdy);
    rst_n          = rst;
    req_if.vld     = vld;
    req_if.pkt.pc  = pc;
    rsp_if.rdy     = rrdy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] randPc();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return $urandom | 32'h0001_0000;
    if (r == 1) return ($urandom_range(0, MEM_WORDS - 1) * 4) + $urandom_range(1, 3);
    return $urandom_range(0, MEM_WORDS - 1) * 4;
  endfunction

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom | 32'h1;
    mem[2] = 32'h00A00093;
    rst_n         = 1'b0;
    req_if.vld    = 1'b0;
    req_if.pkt.pc = '0;
    rsp_if.rdy    = 1'b0;
    #1;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // single fetch
    applyStimulus(1, 1, 32'h8, 1);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);

    // back-to-back streaming
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, i * 4, 1);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);

    // back-pressure: third request stalls until the first response leaves
    applyStimulus(1, 1, 32'h0, 0);
    applyStimulus(1, 1, 32'h4, 0);
    applyStimulus(1, 1, 32'h8, 0);
    applyStimulus(1, 1, 32'h8, 0);
    applyStimulus(1, 1, 32'h8, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 1);

    // bypass falls back to the FIFO when ready drops in the return cycle
    applyStimulus(1, 1, 32'h10, 1);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);

    // bad PCs: misaligned and just past the end of memory
    applyStimulus(1, 1, 32'h2, 1);
    applyStimulus(1, 1, MEM_WORDS * 4, 1);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);
    checkOutput("fault_sticky", {31'b0, fault}, 32'd1);

    // reset with two requests outstanding
    applyStimulus(1, 1, 32'hC, 0);
    applyStimulus(1, 1, 32'h14, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("post_rst_vld", {31'b0, rsp_if.vld}, 32'd0);
    checkOutput("post_rst_fault", {31'b0, fault}, 32'd0);
    applyStimulus(1, 0, 0, 1);

    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, randPc(),
                    $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
